// File: rtl/mac_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : mac_result_collector
// Brief    : First-word fall-through result FIFO behind a MAC unit, with a
//            sticky overflow flag. Optional 16-bit saturation on store is
//            enabled by defining MAC_COLLECT_SAT16_EN.
// Revision : 1.0
// ============================================================================
module mac_result_collector #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   done,
    input  logic [DATA_W-1:0]      y,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   drop,
`ifdef MAC_COLLECT_SAT16_EN
    output logic                   sat,
`endif
    input  logic                   clr_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic              drop_q, drop_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              push;
    logic              pop;
    logic [DATA_W-1:0] wdata;

`ifdef MAC_COLLECT_SAT16_EN
    logic              sat_q, sat_d;
    logic              clamped;
    logic [DATA_W-16:0] y_hi;

    assign y_hi = y[DATA_W-1:15];
    // y fits in 16 bits exactly when every bit from 15 upward equals the sign
    assign clamped = !((&y_hi) || !(|y_hi));
    assign wdata   = !clamped   ? y :
                     y[DATA_W-1] ? {{(DATA_W-15){1'b1}}, 15'd0}
                                 : {{(DATA_W-15){1'b0}}, {15{1'b1}}};
    assign sat     = sat_q;
`else
    assign wdata   = y;
`endif

    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign count     = count_q;
    assign drop      = drop_q;

    assign pop  = out_valid && out_ready;
    assign push = done && ((state_q != ST_FULL) || pop);

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        drop_d   = drop_q;
        state_d  = state_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A fresh loss wins over a same-cycle clear
        if (clr_drop) begin
            drop_d = 1'b0;
        end
        if (done && !push) begin
            drop_d = 1'b1;
        end

        if (count_d == '0) begin
            state_d = ST_EMPTY;
        end else if (count_d == CW'(DEPTH)) begin
            state_d = ST_FULL;
        end else begin
            state_d = ST_PARTIAL;
        end
    end

`ifdef MAC_COLLECT_SAT16_EN
    always_comb begin
        sat_d = push && clamped;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_EMPTY;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            drop_q   <= 1'b0;
`ifdef MAC_COLLECT_SAT16_EN
            sat_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            drop_q   <= drop_d;
`ifdef MAC_COLLECT_SAT16_EN
            sat_q    <= sat_d;
`endif
        end
    end

    // Storage is left uninitialised; out_data is masked while empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule
`default_nettype wire
